// File: rtl/timer_countdown.sv
// Egg-timer time-keeping datapath: latches min/sec from switches, counts down once
// per tick while enabled, reports 00:00 and drives the alarm LED blink pattern.
module timer_countdown #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int FLASH_DIV = 12_500_000,
  parameter int MAX_MIN   = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] sw_val,
  input  logic       sw_sec_en,
  input  logic       sw_min_en,
  input  logic       secs_set,
  input  logic       mins_set,
  input  logic       dec_en,
  input  logic       flash_en,
  output logic [6:0] disp_min,
  output logic [5:0] disp_sec,
  output logic       time_flat,
  output logic       led
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int FW = (FLASH_DIV > 2) ? $clog2(FLASH_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);
  localparam logic [6:0]    MIN_CAP    = 7'(MAX_MIN);

  logic [6:0]    min_r;
  logic [5:0]    sec_r;
  logic [TW-1:0] tick_cnt;
  logic [FW-1:0] flash_cnt;
  logic [5:0]    sec_v;
  logic [6:0]    min_v;
  logic          tick;

  function automatic logic [5:0] sat_sec(input logic [6:0] v);
    return (v > 7'd59) ? 6'd59 : v[5:0];
  endfunction

  function automatic logic [6:0] sat_min(input logic [6:0] v);
    return (v > MIN_CAP) ? MIN_CAP : v;
  endfunction

  always_comb begin
    sec_v     = sat_sec(sw_val);
    min_v     = sat_min(sw_val);
    tick      = dec_en && (tick_cnt == TICK_LAST);
    disp_sec  = sw_sec_en ? sec_v : sec_r;
    disp_min  = sw_min_en ? min_v : min_r;
    time_flat = (min_r == 7'd0) && (sec_r == 6'd0);
  end

  // One-second prescaler; dropping dec_en discards any partial second.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (!dec_en || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Time registers: a load strobe suppresses the decrement for that cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_r <= '0;
      sec_r <= '0;
    end else if (secs_set || mins_set) begin
      if (secs_set) sec_r <= sec_v;
      if (mins_set) min_r <= min_v;
    end else if (tick) begin
      if (sec_r != 6'd0) begin
        sec_r <= sec_r - 6'd1;
      end else if (min_r != 7'd0) begin
        min_r <= min_r - 7'd1;
        sec_r <= 6'd59;
      end
    end
  end

  // LED blink: toggle on every prescaler wrap, forced dark outside flash.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flash_cnt <= '0;
      led       <= 1'b0;
    end else if (!flash_en) begin
      flash_cnt <= '0;
      led       <= 1'b0;
    end else if (flash_cnt == FLASH_LAST) begin
      flash_cnt <= '0;
      led       <= ~led;
    end else begin
      flash_cnt <= flash_cnt + FW'(1);
    end
  end

endmodule

// File: tb/tb_timer_countdown.sv
// Bench for timer_countdown: directed scenarios plus random traffic, checked against
// a total-seconds model of the timer with cycle-count based tick and blink rules.
module tb_timer_countdown;
  localparam int TICK_DIV  = 4;
  localparam int FLASH_DIV = 3;
  localparam int MAX_MIN   = 99;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] sw_val;
  logic       sw_sec_en, sw_min_en, secs_set, mins_set, dec_en, flash_en;
  logic [6:0] disp_min;
  logic [5:0] disp_sec;
  logic       time_flat, led;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int total_s;   // stored time in seconds
  int run_n;     // consecutive cycles with dec_en high
  int fl_n;      // consecutive cycles with flash_en high
  int led_m;

  timer_countdown #(.TICK_DIV(TICK_DIV), .FLASH_DIV(FLASH_DIV), .MAX_MIN(MAX_MIN)) dut (
    .clk(clk), .reset(reset), .sw_val(sw_val), .sw_sec_en(sw_sec_en), .sw_min_en(sw_min_en),
    .secs_set(secs_set), .mins_set(mins_set), .dec_en(dec_en), .flash_en(flash_en),
    .disp_min(disp_min), .disp_sec(disp_sec), .time_flat(time_flat), .led(led)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    total_s = 0;
    run_n   = 0;
    fl_n    = 0;
    led_m   = 0;
  endtask

  // Apply one posedge worth of the timer rules to the model.
  task automatic model_step();
    bit tk;
    int m, s;
    if (dec_en) begin
      run_n++;
      tk = (run_n % TICK_DIV) == 0;
    end else begin
      run_n = 0;
      tk = 0;
    end
    if (secs_set || mins_set) begin
      m = total_s / 60;
      s = total_s % 60;
      if (secs_set) s = clamp(int'(sw_val), 59);
      if (mins_set) m = clamp(int'(sw_val), MAX_MIN);
      total_s = m * 60 + s;
    end else if (tk && total_s > 0) begin
      total_s--;
    end
    if (flash_en) begin
      fl_n++;
      led_m = (fl_n / FLASH_DIV) % 2;
    end else begin
      fl_n  = 0;
      led_m = 0;
    end
  endtask

  task automatic check_all(input string tag);
    int exp_sec, exp_min;
    exp_sec = sw_sec_en ? clamp(int'(sw_val), 59) : total_s % 60;
    exp_min = sw_min_en ? clamp(int'(sw_val), MAX_MIN) : total_s / 60;
    chk({tag, ".disp_sec"}, int'(disp_sec), exp_sec);
    chk({tag, ".disp_min"}, int'(disp_min), exp_min);
    chk({tag, ".time_flat"}, int'(time_flat), int'(total_s == 0));
    chk({tag, ".led"}, int'(led), led_m);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    #1;
    check_all(tag);
  endtask

  task automatic load(input int mm, input int ss);
    sw_val = 7'(ss); secs_set = 1; cycle("load_s"); secs_set = 0;
    sw_val = 7'(mm); mins_set = 1; cycle("load_m"); mins_set = 0;
  endtask

  initial begin
    reset = 0; sw_val = 0; sw_sec_en = 0; sw_min_en = 0;
    secs_set = 0; mins_set = 0; dec_en = 0; flash_en = 0;
    model_reset();
    repeat (2) cycle("reset");
    chk("reset.flat_const", int'(time_flat), 1);
    #2 reset = 1;

    // Saturating loads
    sw_val = 75; secs_set = 1; cycle("sat_s"); secs_set = 0;
    sw_val = 120; mins_set = 1; cycle("sat_m"); mins_set = 0;
    chk("sat.sec_const", int'(disp_sec), 59);
    chk("sat.min_const", int'(disp_min), 99);
    chk("sat.flat_const", int'(time_flat), 0);

    // Countdown 01:02 to 00:00 and hold
    load(1, 2);
    dec_en = 1;
    repeat (4) cycle("run");
    chk("run4.sec_const", int'(disp_sec), 1);
    repeat (4) cycle("run");
    chk("run8.sec_const", int'(disp_sec), 0);
    repeat (4) cycle("run");
    chk("run12.min_const", int'(disp_min), 0);
    chk("run12.sec_const", int'(disp_sec), 59);
    repeat (235) cycle("run");
    chk("run247.flat_const", int'(time_flat), 0);
    cycle("run");
    chk("run248.flat_const", int'(time_flat), 1);
    repeat (10) cycle("hold");
    chk("hold.sec_const", int'(disp_sec), 0);
    dec_en = 0;

    // Stop/restart discards partial second
    load(0, 5);
    dec_en = 1; repeat (6) cycle("sr_a");
    dec_en = 0; repeat (3) cycle("sr_b");
    dec_en = 1; repeat (3) cycle("sr_c");
    chk("sr.sec_before", int'(disp_sec), 4);
    cycle("sr_d");
    chk("sr.sec_after", int'(disp_sec), 3);
    dec_en = 0;

    // Seconds preview
    load(0, 10);
    sw_sec_en = 1; sw_val = 30; cycle("prev_on");
    chk("prev.on_const", int'(disp_sec), 30);
    sw_sec_en = 0; cycle("prev_off");
    chk("prev.off_const", int'(disp_sec), 10);

    // Flash pattern
    flash_en = 1;
    for (int i = 1; i <= 12; i++) begin
      cycle("flash");
      if (i == 3) chk("flash3.led_const", int'(led), 1);
      if (i == 6) chk("flash6.led_const", int'(led), 0);
    end
    flash_en = 1; cycle("flash13");
    flash_en = 0; cycle("flash_off");
    chk("flash_off.led_const", int'(led), 0);

    // Async reset mid-run with LED lit
    load(0, 7);
    dec_en = 1; flash_en = 1;
    repeat (5) cycle("pre_rst");
    #1 reset = 0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.flat_const", int'(time_flat), 1);
    #1 reset = 1;
    flash_en = 0;

    // Load colliding with a tick: load wins
    load(0, 7);
    dec_en = 1;
    repeat (3) cycle("coll_a");
    sw_val = 20; secs_set = 1; cycle("coll_b"); secs_set = 0;
    chk("coll.sec_const", int'(disp_sec), 20);
    dec_en = 0; cycle("coll_c");

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      sw_val    = 7'($urandom_range(0, 127));
      sw_sec_en = ($urandom_range(0, 7) == 0);
      sw_min_en = ($urandom_range(0, 7) == 0);
      secs_set  = ($urandom_range(0, 19) == 0);
      mins_set  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 15) == 0) dec_en = ~dec_en;
      if ($urandom_range(0, 23) == 0) flash_en = ~flash_en;
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
